framebuffer_ctrl: RTL and testbench
===================================

FRAMEBUFFER_CTRL -- requirements
Module: framebuffer_ctrl

Interface
REQ-001 SHALL have parameter rows, default 8, addressable display rows.
REQ-002 SHALL have parameter columns, default 32, pixels per row.
REQ-003 SHALL have parameter data_width, default 24, pixel word width.
REQ-004 SHALL derive RW=$clog2(rows), CW=$clog2(columns), AW=1+RW+CW; address = {bank, row, col}.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 safe_flip  in  1  one-cycle flip window pulse from display driver.
REQ-008 rd_row  in  RW  display driver row counter.
REQ-009 rd_col  in  CW  display driver column counter.
REQ-010 wr_valid  in  1  host pixel write request.
REQ-011 wr_ready  out  1  host write accepted when wr_valid & wr_ready.
REQ-012 wr_row / wr_col / wr_data  in  RW / CW / data_width  host pixel address and value.
REQ-013 flip_req  in  1  host request to swap front and back banks.
REQ-014 clear_en  in  1  sampled with flip_req; zero new back bank after swap.
REQ-015 flip_busy  out  1  flip or clear in progress.
REQ-016 flip_done  out  1  one-cycle completion pulse.
REQ-017 front  out  1  bank currently displayed.
REQ-018 flip_count  out  8  completed flips, wraps 255->0.
REQ-019 ram_raddr  out  AW  display read address, combinational {front, rd_row, rd_col}.
REQ-020 ram_we / ram_waddr / ram_wdata  out  1 / AW / data_width  registered BRAM write port.

Function
REQ-021 SHALL implement states IDLE, FLIP_WAIT, CLEAR; back bank is always ~front.
REQ-022 IDLE: wr_ready=1, flip_busy=0; all other states: wr_ready=0, flip_busy=1.
REQ-023 Accepted host write SHALL drive ram_we=1, ram_waddr={~front, wr_row, wr_col}, ram_wdata=wr_data on the next cycle (1-cycle latency); otherwise ram_we=0.
REQ-024 IDLE with flip_req=1: register clear_en, go FLIP_WAIT; a write accepted in the same cycle SHALL still target the pre-flip back bank.
REQ-025 safe_flip in IDLE or CLEAR SHALL be ignored; safe_flip coincident with flip_req in IDLE SHALL NOT complete the flip.
REQ-026 FLIP_WAIT with safe_flip=1: toggle front, increment flip_count; go CLEAR if registered clear_en=1, else go IDLE and assert flip_done for one cycle.
REQ-027 flip_req outside IDLE SHALL be ignored (no queueing).
REQ-028 CLEAR: linear counter 0..rows*columns-1; each cycle write ram_wdata=0 to {~front, counter}, using row-major order (row=counter/columns, col=counter%columns); rows*columns cycles total.
REQ-029 CLEAR SHALL assert flip_done for one cycle on the entry to IDLE after the last address is written.
REQ-030 Write port arbitration: the clear engine SHALL own ram_we in CLEAR; host writes SHALL never be accepted outside IDLE.
REQ-031 Out-of-range wr_row/wr_col (non-power-of-2 sizes) SHALL be written unmodified; no range check.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, front=0, flip_count=0, flip_done=0, ram_we=0, ram_waddr=0, ram_wdata=0, clear counter=0.
REQ-033 Reset mid-FLIP_WAIT or mid-CLEAR SHALL abandon the operation with no flip_done pulse; the first cycle after release is IDLE with wr_ready=1.

Verification
REQ-034 Write wr_row=3, wr_col=5, wr_data=0xABCDEF after reset -> next cycle ram_we=1, ram_waddr=0x165 ({1,3,5}), ram_wdata=0xABCDEF.
REQ-035 flip_req=1 clear_en=0, safe_flip pulse 10 cycles later -> flip_busy=1 for those cycles, wr_ready=0, front 0->1, flip_count=1, flip_done one cycle; rd_row=2, rd_col=7 then gives ram_raddr=0x147.
REQ-036 flip_req and safe_flip both high in the same IDLE cycle -> front unchanged; next safe_flip completes the flip.
REQ-037 flip with clear_en=1 (rows=8, columns=32) -> after swap 256 consecutive ram_we cycles, addresses {~front,0..255}, data 0, then flip_done one cycle and wr_ready=1.
REQ-038 Assert rst at clear address 100 -> front=0, ram_we=0 immediately, no flip_done; 256 flips wrap flip_count to 0.

Source files
------------

// File: rtl/framebuffer_ctrl.sv
// framebuffer_ctrl: double-buffered framebuffer bank controller.
// The display reads from the front bank while the host writes pixels into the
// back bank (always ~front). A host flip request arms a bank swap that only
// completes on the display driver's safe_flip window, and can optionally be
// followed by zeroing the new back bank through the shared BRAM write port.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | host writes accepted, waiting for flip_req
// ST_FLIP_WAIT | flip armed, waiting for safe_flip to swap banks
// ST_CLEAR     | clear engine owns the write port, zeroing the back bank
module framebuffer_ctrl #(
    parameter int rows       = 8,
    parameter int columns    = 32,
    parameter int data_width = 24,
    localparam int RW = $clog2(rows),
    localparam int CW = $clog2(columns),
    localparam int AW = 1 + RW + CW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  safe_flip,
    input  logic [RW-1:0]         rd_row,
    input  logic [CW-1:0]         rd_col,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [RW-1:0]         wr_row,
    input  logic [CW-1:0]         wr_col,
    input  logic [data_width-1:0] wr_data,
    input  logic                  flip_req,
    input  logic                  clear_en,
    output logic                  flip_busy,
    output logic                  flip_done,
    output logic                  front,
    output logic [7:0]            flip_count,
    output logic [AW-1:0]         ram_raddr,
    output logic                  ram_we,
    output logic [AW-1:0]         ram_waddr,
    output logic [data_width-1:0] ram_wdata
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FLIP_WAIT = 2'd1,
        ST_CLEAR     = 2'd2
    } state_t;

    localparam logic [RW-1:0] ROW_LAST = RW'(rows - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(columns - 1);

    state_t                state_q, state_d;
    logic                  front_q, front_d;
    logic [7:0]            flip_count_q, flip_count_d;
    logic                  clear_en_q, clear_en_d;
    logic                  flip_done_q, flip_done_d;
    logic                  ram_we_q, ram_we_d;
    logic [AW-1:0]         ram_waddr_q, ram_waddr_d;
    logic [data_width-1:0] ram_wdata_q, ram_wdata_d;
    // The clear counter is kept as a row/col pair: stepped row-major it is the
    // linear pixel index split as index/columns and index%columns, without
    // needing a divider for non-power-of-2 column counts.
    logic [RW-1:0]         clr_row_q, clr_row_d;
    logic [CW-1:0]         clr_col_q, clr_col_d;
    logic                  clr_last;

    assign clr_last = (clr_row_q == ROW_LAST) && (clr_col_q == COL_LAST);

    // Next-state, write-port arbitration and clear-engine sequencing.
    always_comb begin
        state_d      = state_q;
        front_d      = front_q;
        flip_count_d = flip_count_q;
        clear_en_d   = clear_en_q;
        flip_done_d  = 1'b0;
        ram_we_d     = 1'b0;
        ram_waddr_d  = ram_waddr_q;
        ram_wdata_d  = ram_wdata_q;
        clr_row_d    = clr_row_q;
        clr_col_d    = clr_col_q;

        case (state_q)
            ST_IDLE: begin
                // The write uses the current front, so a write landing in the
                // same cycle as flip_req still goes to the pre-flip back bank.
                if (wr_valid) begin
                    ram_we_d    = 1'b1;
                    ram_waddr_d = {~front_q, wr_row, wr_col};
                    ram_wdata_d = wr_data;
                end
                // safe_flip is deliberately not looked at here.
                if (flip_req) begin
                    clear_en_d = clear_en;
                    state_d    = ST_FLIP_WAIT;
                end
            end

            ST_FLIP_WAIT: begin
                if (safe_flip) begin
                    front_d      = ~front_q;
                    flip_count_d = flip_count_q + 8'd1;
                    if (clear_en_q) begin
                        clr_row_d = '0;
                        clr_col_d = '0;
                        state_d   = ST_CLEAR;
                    end else begin
                        flip_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end

            ST_CLEAR: begin
                // front_q is already the new front, so ~front_q is the bank
                // that just left the display.
                ram_we_d    = 1'b1;
                ram_waddr_d = {~front_q, clr_row_q, clr_col_q};
                ram_wdata_d = '0;
                if (clr_last) begin
                    clr_row_d   = '0;
                    clr_col_d   = '0;
                    flip_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (clr_col_q == COL_LAST) begin
                    clr_col_d = '0;
                    clr_row_d = clr_row_q + RW'(1);
                end else begin
                    clr_col_d = clr_col_q + CW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any flip or clear in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            front_q      <= 1'b0;
            flip_count_q <= 8'd0;
            clear_en_q   <= 1'b0;
            flip_done_q  <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_waddr_q  <= '0;
            ram_wdata_q  <= '0;
            clr_row_q    <= '0;
            clr_col_q    <= '0;
        end else begin
            state_q      <= state_d;
            front_q      <= front_d;
            flip_count_q <= flip_count_d;
            clear_en_q   <= clear_en_d;
            flip_done_q  <= flip_done_d;
            ram_we_q     <= ram_we_d;
            ram_waddr_q  <= ram_waddr_d;
            ram_wdata_q  <= ram_wdata_d;
            clr_row_q    <= clr_row_d;
            clr_col_q    <= clr_col_d;
        end
    end

    assign wr_ready   = (state_q == ST_IDLE);
    assign flip_busy  = (state_q != ST_IDLE);
    assign flip_done  = flip_done_q;
    assign front      = front_q;
    assign flip_count = flip_count_q;
    assign ram_raddr  = {front_q, rd_row, rd_col};
    assign ram_we     = ram_we_q;
    assign ram_waddr  = ram_waddr_q;
    assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_framebuffer_ctrl.sv
// Testbench for framebuffer_ctrl: directed vector table, hand-written
// multi-cycle sequences for clear / reset corners, and randomized traffic
// checked against a pixel-index arithmetic reference model.
module tb_framebuffer_ctrl;

    localparam int ROWS = 8;
    localparam int COLS = 32;
    localparam int DW   = 24;
    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS);
    localparam int AW   = 1 + RW + CW;
    localparam int PIX  = ROWS * COLS;

    logic          clk = 1'b0;
    logic          rst;
    logic          safe_flip;
    logic [RW-1:0] rd_row;
    logic [CW-1:0] rd_col;
    logic          wr_valid;
    logic          wr_ready;
    logic [RW-1:0] wr_row;
    logic [CW-1:0] wr_col;
    logic [DW-1:0] wr_data;
    logic          flip_req;
    logic          clear_en;
    logic          flip_busy;
    logic          flip_done;
    logic          front;
    logic [7:0]    flip_count;
    logic [AW-1:0] ram_raddr;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;

    framebuffer_ctrl #(.rows(ROWS), .columns(COLS), .data_width(DW)) dut (
        .clk(clk), .rst(rst), .safe_flip(safe_flip),
        .rd_row(rd_row), .rd_col(rd_col),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .flip_req(flip_req), .clear_en(clear_en),
        .flip_busy(flip_busy), .flip_done(flip_done),
        .front(front), .flip_count(flip_count),
        .ram_raddr(ram_raddr), .ram_we(ram_we),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        safe_flip = 1'b0; wr_valid = 1'b0; flip_req = 1'b0; clear_en = 1'b0;
        wr_row = '0; wr_col = '0; wr_data = '0; rd_row = '0; rd_col = '0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          wv;
        logic [RW-1:0] wr;
        logic [CW-1:0] wc;
        logic [DW-1:0] wd;
        logic          fr, ce, sf;
        logic [RW-1:0] rr;
        logic [CW-1:0] rc;
        logic          e_we;
        logic [AW-1:0] e_waddr;
        logic [DW-1:0] e_wdata;
        logic          e_front;
        logic [7:0]    e_cnt;
        logic          e_done, e_ready;
        logic [AW-1:0] e_raddr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic wv, input int wr, input int wc, input int wd,
                       input logic fr, input logic ce, input logic sf,
                       input int rr, input int rc,
                       input logic e_we, input int e_waddr, input int e_wdata,
                       input logic e_front, input int e_cnt,
                       input logic e_done, input logic e_ready, input int e_raddr);
        vec_t v;
        v.wv = wv; v.wr = RW'(wr); v.wc = CW'(wc); v.wd = DW'(wd);
        v.fr = fr; v.ce = ce; v.sf = sf; v.rr = RW'(rr); v.rc = CW'(rc);
        v.e_we = e_we; v.e_waddr = AW'(e_waddr); v.e_wdata = DW'(e_wdata);
        v.e_front = e_front; v.e_cnt = 8'(e_cnt);
        v.e_done = e_done; v.e_ready = e_ready; v.e_raddr = AW'(e_raddr);
        tbl.push_back(v);
    endtask

    // ---------------- reference model ----------------
    // mode: 0 = accepting writes, 1 = flip armed, 2 = clearing back bank
    int m_mode, m_front, m_count, m_clr, m_idx;
    int exp_we, exp_addr, exp_data, exp_done;

    task automatic model_reset();
        m_mode = 0; m_front = 0; m_count = 0; m_clr = 0; m_idx = 0;
        exp_we = 0; exp_addr = 0; exp_data = 0; exp_done = 0;
    endtask

    // Predict the outputs visible after the coming clock edge.
    task automatic model_step();
        exp_we = 0;
        exp_done = 0;
        if (rst) begin
            model_reset();
            return;
        end
        case (m_mode)
            0: begin
                if (wr_valid) begin
                    exp_we   = 1;
                    exp_addr = (1 - m_front) * PIX + int'(wr_row) * COLS + int'(wr_col);
                    exp_data = int'(wr_data);
                end
                if (flip_req) begin
                    m_clr  = int'(clear_en);
                    m_mode = 1;
                end
            end
            1: begin
                if (safe_flip) begin
                    m_front = 1 - m_front;
                    m_count = (m_count + 1) % 256;
                    if (m_clr != 0) begin
                        m_mode = 2;
                        m_idx  = 0;
                    end else begin
                        m_mode   = 0;
                        exp_done = 1;
                    end
                end
            end
            default: begin
                exp_we   = 1;
                exp_addr = (1 - m_front) * PIX + m_idx;
                exp_data = 0;
                m_idx++;
                if (m_idx == PIX) begin
                    m_mode   = 0;
                    exp_done = 1;
                end
            end
        endcase
    endtask

    task automatic check_model();
        chk("rnd_we", ram_we, exp_we);
        if (exp_we != 0) begin
            chk("rnd_waddr", ram_waddr, exp_addr);
            chk("rnd_wdata", ram_wdata, exp_data);
        end
        chk("rnd_front", front, m_front);
        chk("rnd_count", flip_count, m_count);
        chk("rnd_done", flip_done, exp_done);
        chk("rnd_ready", wr_ready, m_mode == 0);
        chk("rnd_busy", flip_busy, m_mode != 0);
        chk("rnd_raddr", ram_raddr, m_front * PIX + int'(rd_row) * COLS + int'(rd_col));
    endtask

    initial begin
        int  k;
        logic done_seen;
        logic found;
        logic [31:0] r;

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_front", front, 0);
        chk("reset_count", flip_count, 0);
        chk("reset_we", ram_we, 0);
        chk("reset_waddr", ram_waddr, 0);
        chk("reset_wdata", ram_wdata, 0);
        chk("reset_done", flip_done, 0);
        chk("reset_ready", wr_ready, 1);
        chk("reset_busy", flip_busy, 0);
        rst = 1'b0;

        // wv wr wc wd        fr ce sf rr rc | we waddr wdata   fr cnt dn rdy raddr
        add(1, 3, 5, 'hABCDEF, 0, 0, 0, 0, 0,  1, 'h165, 'hABCDEF, 0, 0, 0, 1, 'h000);
        add(0, 0, 0, 0,        0, 0, 0, 2, 7,  0, 0, 0,           0, 0, 0, 1, 'h047);
        add(1, 1, 2, 'h123456, 1, 0, 0, 2, 7,  1, 'h122, 'h123456, 0, 0, 0, 0, 'h047);
        for (int i = 0; i < 9; i++)
            add(1, 4, 4, 'h777777, 1, 1, 0, 2, 7, 0, 0, 0, 0, 0, 0, 0, 'h047);
        add(0, 0, 0, 0,        0, 0, 1, 2, 7,  0, 0, 0,           1, 1, 1, 1, 'h147);
        add(0, 0, 0, 0,        0, 0, 0, 2, 7,  0, 0, 0,           1, 1, 0, 1, 'h147);
        add(0, 0, 0, 0,        1, 0, 1, 2, 7,  0, 0, 0,           1, 1, 0, 0, 'h147);
        add(0, 0, 0, 0,        0, 0, 0, 2, 7,  0, 0, 0,           1, 1, 0, 0, 'h147);
        add(0, 0, 0, 0,        0, 0, 1, 2, 7,  0, 0, 0,           0, 2, 1, 1, 'h047);
        add(0, 0, 0, 0,        0, 0, 1, 2, 7,  0, 0, 0,           0, 2, 0, 1, 'h047);
        add(1, 7, 31, 'hFFFFFF, 0, 0, 0, 7, 31, 1, 'h1FF, 'hFFFFFF, 0, 2, 0, 1, 'h0FF);

        foreach (tbl[i]) begin
            wr_valid = tbl[i].wv; wr_row = tbl[i].wr; wr_col = tbl[i].wc; wr_data = tbl[i].wd;
            flip_req = tbl[i].fr; clear_en = tbl[i].ce; safe_flip = tbl[i].sf;
            rd_row = tbl[i].rr; rd_col = tbl[i].rc;
            tick();
            chk($sformatf("vec%0d_we", i), ram_we, tbl[i].e_we);
            if (tbl[i].e_we) begin
                chk($sformatf("vec%0d_waddr", i), ram_waddr, tbl[i].e_waddr);
                chk($sformatf("vec%0d_wdata", i), ram_wdata, tbl[i].e_wdata);
            end
            chk($sformatf("vec%0d_front", i), front, tbl[i].e_front);
            chk($sformatf("vec%0d_count", i), flip_count, tbl[i].e_cnt);
            chk($sformatf("vec%0d_done", i), flip_done, tbl[i].e_done);
            chk($sformatf("vec%0d_ready", i), wr_ready, tbl[i].e_ready);
            chk($sformatf("vec%0d_busy", i), flip_busy, !tbl[i].e_ready);
            chk($sformatf("vec%0d_raddr", i), ram_raddr, tbl[i].e_raddr);
        end
        idle_inputs();

        // ---- flip with clear: full back-bank zeroing ----
        flip_req = 1'b1; clear_en = 1'b1;
        tick();
        flip_req = 1'b0; clear_en = 1'b0;
        chk("clr_arm_busy", flip_busy, 1);
        tick();
        safe_flip = 1'b1;
        tick();
        safe_flip = 1'b0;
        chk("clr_swap_front", front, 1);
        chk("clr_swap_count", flip_count, 3);
        chk("clr_swap_done", flip_done, 0);
        chk("clr_swap_ready", wr_ready, 0);
        chk("clr_swap_we", ram_we, 0);
        wr_valid = 1'b1; wr_data = 'h555555; wr_row = 3; wr_col = 3;
        k = 0;
        done_seen = 1'b0;
        for (int c = 0; c < 300 && !done_seen; c++) begin
            tick();
            if (ram_we) begin
                chk("clr_addr", ram_waddr, (1 - int'(front)) * PIX + k);
                chk("clr_data", ram_wdata, 0);
                k++;
            end else if (k > 0) begin
                chk("clr_gap", ram_we, 1);
            end
            if (flip_done) begin
                done_seen = 1'b1;
                chk("clr_done_ready", wr_ready, 1);
                chk("clr_len", k, PIX);
            end
        end
        wr_valid = 1'b0;
        chk("clr_done_seen", done_seen, 1);
        tick();
        chk("clr_after_done", flip_done, 0);
        chk("clr_after_we", ram_we, 0);

        // ---- reset in the middle of a clear ----
        flip_req = 1'b1; clear_en = 1'b1;
        tick();
        flip_req = 1'b0; clear_en = 1'b0;
        safe_flip = 1'b1;
        tick();
        safe_flip = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            tick();
            if (ram_we && ram_waddr[RW+CW-1:0] == (RW+CW)'(100)) found = 1'b1;
        end
        chk("rstclr_reached_100", found, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstclr_front", front, 0);
        chk("rstclr_we", ram_we, 0);
        chk("rstclr_done", flip_done, 0);
        chk("rstclr_count", flip_count, 0);
        chk("rstclr_ready", wr_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rstclr_rel_ready", wr_ready, 1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("rstclr_no_done", flip_done, 0);
            chk("rstclr_no_we", ram_we, 0);
        end

        // ---- reset while flip is armed ----
        flip_req = 1'b1;
        tick();
        flip_req = 1'b0;
        chk("rstwait_busy", flip_busy, 1);
        rst = 1'b1;
        #1;
        chk("rstwait_busy_cleared", flip_busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        safe_flip = 1'b1;
        tick();
        safe_flip = 1'b0;
        chk("rstwait_front", front, 0);
        chk("rstwait_done", flip_done, 0);

        // ---- 256 flips wrap the counter ----
        for (int i = 0; i < 256; i++) begin
            flip_req = 1'b1;
            tick();
            flip_req = 1'b0;
            safe_flip = 1'b1;
            tick();
            safe_flip = 1'b0;
            chk("wrap_done", flip_done, 1);
            if (i == 254) chk("wrap_255", flip_count, 255);
        end
        chk("wrap_count", flip_count, 0);
        chk("wrap_front", front, 0);

        // ---- randomized traffic against the reference model ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            r = $urandom;
            rst       = (r[11:0] < 12'd6);
            wr_valid  = r[12];
            flip_req  = (r[16:13] == 4'd0);
            clear_en  = r[17];
            safe_flip = (r[20:18] == 3'd0);
            r = $urandom;
            wr_row = r[RW-1:0];
            wr_col = r[RW+CW-1:RW];
            rd_row = r[2*RW+CW-1:RW+CW];
            rd_col = r[2*RW+2*CW-1:2*RW+CW];
            r = $urandom;
            wr_data = r[DW-1:0];
            model_step();
            tick();
            check_model();
        end
        rst = 1'b0;
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
